// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the multi-port register file.
//   wr_size_e : sub-register write size encodings
//   lane_mask : maps a write size to a byte-lane enable mask
package regfile_pkg;

  // Widest register supported by lane_mask, expressed in byte lanes.
  localparam int MAX_LANES = 64;

  typedef enum logic [1:0] {
    SZ_B0   = 2'b00,  // bits [7:0]
    SZ_B1   = 2'b01,  // bits [15:8]
    SZ_W    = 2'b10,  // bits [15:0]
    SZ_FULL = 2'b11   // all bits
  } wr_size_e;

  // Bit l of the result enables byte lane l. Callers truncate the result
  // to their own lane count.
  function automatic logic [MAX_LANES-1:0] lane_mask(input logic [1:0] size,
                                                     input int nlanes);
    logic [MAX_LANES-1:0] m;
    m = '0;
    case (size)
      SZ_B0:   m[0] = 1'b1;
      SZ_B1:   m[1] = 1'b1;
      SZ_W:    m[1:0] = 2'b11;
      default: m = {MAX_LANES{1'b1}} >> (MAX_LANES - nlanes);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/regfile_lane_merge.sv
// regfile_lane_merge: byte-lane merge of one write port onto a register value.
//   old_val in  WIDTH  value before this port's write
//   data    in  WIDTH  right-aligned write data
//   size    in  2      write size (wr_size_e encoding)
//   merged  out WIDTH  old_val with the selected lanes replaced
module regfile_lane_merge
  import regfile_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] old_val,
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       size,
  output logic [WIDTH-1:0] merged
);

  localparam int NL = WIDTH / 8;

  logic [WIDTH-1:0] aligned;
  logic [NL-1:0]    mask;

  always_comb begin
    // A high-byte write carries its byte in data[7:0]; steer it to lane 1.
    aligned = data;
    if (size == SZ_B1) aligned[15:8] = data[7:0];
    mask   = NL'(lane_mask(size, NL));
    merged = old_val;
    for (int l = 0; l < NL; l++) begin
      if (mask[l]) merged[l*8 +: 8] = aligned[l*8 +: 8];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with sub-register writes.
//   clk      in   1          rising-edge clock
//   rst      in   1          asynchronous active-high reset
//   wr_en    in   NWR        per-port write enable
//   wr_addr  in   NWR*AW     per-port register index
//   wr_size  in   NWR*2      per-port write size (wr_size_e)
//   wr_data  in   NWR*WIDTH  per-port right-aligned write data
//   rd_addr  in   NRD*AW     per-port read index
//   rd_data  out  NRD*WIDTH  per-port combinational read data
//   wr_conf  out  1          two enabled ports hit one address on the last edge
// Build option: define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int               NREGS     = 8,
  parameter int               WIDTH     = 32,
  parameter int               NRD       = 2,
  parameter int               NWR       = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              AW        = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*2-1:0]     wr_size,
  input  logic [NWR*WIDTH-1:0] wr_data,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic                 wr_conf
);

  logic [WIDTH-1:0] regs_q   [NREGS];
  logic [WIDTH-1:0] regs_d   [NREGS];
  logic [WIDTH-1:0] port_val [NWR];
  logic [NREGS-1:0] wr_dec   [NWR];
  logic             wr_conf_d;
  logic             wr_conf_q;

  // One-hot target register per write port, zero when the port is idle.
  always_comb begin
    for (int p = 0; p < NWR; p++) begin
      wr_dec[p] = '0;
      if (wr_en[p]) wr_dec[p][wr_addr[p*AW +: AW]] = 1'b1;
    end
  end

  // Merge chain: port p starts from the result of the highest lower-numbered
  // enabled port aimed at the same register, or from the register itself.
  // Its own output is therefore the full merge of ports 0..p for that
  // register, so the highest-numbered port wins every lane it touches.
  for (genvar p = 0; p < NWR; p++) begin : g_wp
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] old_v;
    logic [WIDTH-1:0] new_v;

    assign addr = wr_addr[p*AW +: AW];

    if (p == 0) begin : g_head
      assign old_v = regs_q[addr];
    end else begin : g_link
      for (genvar q = 0; q < p; q++) begin : g_prev
        logic             hit;
        logic [WIDTH-1:0] v;
        assign hit = wr_en[q] && (g_wp[q].addr == addr);
        if (q == 0) begin : g_base
          assign v = hit ? g_wp[0].new_v : regs_q[addr];
        end else begin : g_step
          assign v = hit ? g_wp[q].new_v : g_prev[q-1].v;
        end
      end
      assign old_v = g_prev[p-1].v;
    end

    regfile_lane_merge #(.WIDTH(WIDTH)) u_merge (
      .old_val (old_v),
      .data    (wr_data[p*WIDTH +: WIDTH]),
      .size    (wr_size[p*2 +: 2]),
      .merged  (new_v)
    );

    assign port_val[p] = new_v;
  end

  // Next register contents and conflict detection.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      regs_d[r] = regs_q[r];
      for (int p = 0; p < NWR; p++) begin
        if (wr_dec[p][r]) regs_d[r] = port_val[p];
      end
    end
    wr_conf_d = 1'b0;
    for (int p = 0; p < NWR; p++) begin
      for (int q = p + 1; q < NWR; q++) begin
        if (|(wr_dec[p] & wr_dec[q])) wr_conf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= RESET_VAL;
      wr_conf_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= regs_d[r];
      wr_conf_q <= wr_conf_d;
    end
  end

  assign wr_conf = wr_conf_q;

  // Read muxes. The forward path is suppressed during reset so reads show
  // the reset contents rather than a write that is about to be dropped.
  always_comb begin
    rd_data = '0;
    for (int q = 0; q < NRD; q++) begin
      rd_data[q*WIDTH +: WIDTH] = regs_q[rd_addr[q*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      if (!rst) begin
        for (int p = 0; p < NWR; p++) begin
          if (wr_dec[p][rd_addr[q*AW +: AW]]) rd_data[q*WIDTH +: WIDTH] = port_val[p];
        end
      end
`else
`endif
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of reset, byte lanes, write conflicts,
// forwarding (build dependent) and multi-port reads of regfile_mp.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int NREGS = 8;
  localparam int WIDTH = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 3;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                 clk     = 1'b0;
  logic                 rst     = 1'b0;
  logic [NWR-1:0]       wr_en   = '0;
  logic [NWR*AW-1:0]    wr_addr = '0;
  logic [NWR*2-1:0]     wr_size = '0;
  logic [NWR*WIDTH-1:0] wr_data = '0;
  logic [NRD*AW-1:0]    rd_addr = '0;
  logic [NRD*WIDTH-1:0] rd_data;
  logic                 wr_conf;

  int n_cmp = 0;
  int n_err = 0;

  logic [WIDTH-1:0] model [NREGS];
  logic [WIDTH-1:0] nxt   [NREGS];
  logic             r_en   [NWR];
  logic [AW-1:0]    r_addr [NWR];
  logic [1:0]       r_size [NWR];
  logic [WIDTH-1:0] r_data [NWR];
  logic [AW-1:0]    ra;
  logic [WIDTH-1:0] exp_rd;
  logic             exp_conf;

  regfile_mp #(
    .NREGS(NREGS), .WIDTH(WIDTH), .NRD(NRD), .NWR(NWR), .RESET_VAL('0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_size (wr_size),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_conf (wr_conf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                     input logic [WIDTH-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_wr(input int p, input logic en, input logic [AW-1:0] a,
                        input logic [1:0] sz, input logic [WIDTH-1:0] d);
    wr_en[p]              = en;
    wr_addr[p*AW +: AW]   = a;
    wr_size[p*2 +: 2]     = sz;
    wr_data[p*WIDTH +: WIDTH] = d;
  endtask

  task automatic set_rd(input int q, input logic [AW-1:0] a);
    rd_addr[q*AW +: AW] = a;
  endtask

  function automatic logic [WIDTH-1:0] rd(input int q);
    return rd_data[q*WIDTH +: WIDTH];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edge, then drop the write enables and let reads settle.
  task automatic commit();
    tick();
    wr_en = '0;
    #1;
  endtask

  function automatic logic [WIDTH-1:0] ref_merge(input logic [WIDTH-1:0] old,
                                                 input logic [1:0] sz,
                                                 input logic [WIDTH-1:0] d);
    case (sz)
      2'b00:   return {old[31:8], d[7:0]};
      2'b01:   return {old[31:16], d[7:0], old[7:0]};
      2'b10:   return {old[31:16], d[15:0]};
      default: return d;
    endcase
  endfunction

  initial begin
    // ---------------- reset state ----------------
    #1 rst = 1'b1;
    set_rd(0, 3'd3);
    set_rd(1, 3'd6);
    #1;
    chk("rst_rd0", rd(0), 32'h0);
    chk("rst_rd1", rd(1), 32'h0);
    chk("rst_conf", WIDTH'(wr_conf), 32'h0);
    tick();
    rst = 1'b0;

    // ---------------- byte lanes on R3 ----------------
    set_wr(0, 1'b1, 3'd3, SZ_FULL, 32'h11223344);
    commit();
    chk("lane_full", rd(0), 32'h11223344);
    set_wr(0, 1'b1, 3'd3, SZ_B1, 32'h000000AA);
    commit();
    chk("lane_b1", rd(0), 32'h1122AA44);
    set_wr(1, 1'b1, 3'd3, SZ_B0, 32'hFFFFFF55);
    commit();
    chk("lane_b0", rd(0), 32'h1122AA55);
    set_wr(0, 1'b1, 3'd3, SZ_W, 32'h9999BEEF);
    commit();
    chk("lane_w", rd(0), 32'h1122BEEF);

    // ---------------- same-address conflict on R5 ----------------
    set_rd(1, 3'd5);
    set_wr(0, 1'b1, 3'd5, SZ_FULL, 32'hDEADBEEF);
    set_wr(1, 1'b1, 3'd5, SZ_B0, 32'h00000077);
    tick();
    chk("conf_set", WIDTH'(wr_conf), 32'h1);
    wr_en = '0;
    #1;
    chk("conf_merge", rd(1), 32'hDEADBE77);
    tick();
    chk("conf_clear", WIDTH'(wr_conf), 32'h0);
    // Higher port full write overrides the lower port's byte.
    set_wr(0, 1'b1, 3'd5, SZ_B0, 32'h00000011);
    set_wr(1, 1'b1, 3'd5, SZ_FULL, 32'hA5A5A5A5);
    commit();
    chk("conf_hi_wins", rd(1), 32'hA5A5A5A5);

    // ---------------- disjoint writes ----------------
    set_rd(0, 3'd1);
    set_rd(1, 3'd2);
    set_wr(0, 1'b1, 3'd1, SZ_FULL, 32'h0101CAFE);
    set_wr(1, 1'b1, 3'd2, SZ_FULL, 32'h20202020);
    tick();
    chk("disj_conf", WIDTH'(wr_conf), 32'h0);
    wr_en = '0;
    #1;
    chk("disj_r1", rd(0), 32'h0101CAFE);
    chk("disj_r2", rd(1), 32'h20202020);

    // ---------------- forwarding ----------------
    set_rd(0, 3'd4);
    set_rd(1, 3'd4);
    set_wr(0, 1'b1, 3'd4, SZ_FULL, 32'hCAFEF00D);
    #1;
    chk("byp_pre", rd(0), BYP ? 32'hCAFEF00D : 32'h0);
    commit();
    chk("byp_post0", rd(0), 32'hCAFEF00D);
    chk("byp_post1", rd(1), 32'hCAFEF00D);
    set_rd(0, 3'd6);
    set_wr(0, 1'b1, 3'd6, SZ_FULL, 32'h12345678);
    set_wr(1, 1'b1, 3'd6, SZ_B1, 32'h00000099);
    #1;
    chk("byp_conf_pre", rd(0), BYP ? 32'h12349978 : 32'h0);
    tick();
    chk("byp_conf_flag", WIDTH'(wr_conf), 32'h1);
    wr_en = '0;
    #1;
    chk("byp_conf_post", rd(0), 32'h12349978);

    // ---------------- reset mid-stream ----------------
    set_rd(0, 3'd3);
    set_rd(1, 3'd5);
    set_wr(0, 1'b1, 3'd5, SZ_FULL, 32'h00000000);
    set_wr(1, 1'b1, 3'd5, SZ_B0, 32'h00000001);
    tick();
    chk("pre_rst_conf", WIDTH'(wr_conf), 32'h1);
    set_wr(0, 1'b1, 3'd3, SZ_FULL, 32'hFFFFFFFF);
    set_wr(1, 1'b0, 3'd0, SZ_B0, 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_rd0", rd(0), 32'h0);
    chk("rstmid_rd1", rd(1), 32'h0);
    chk("rstmid_conf", WIDTH'(wr_conf), 32'h0);
    tick();
    chk("rstmid_hold", rd(0), 32'h0);
    wr_en = '0;
    rst = 1'b0;
    #1;
    tick();
    chk("rst_drop", rd(0), 32'h0);
    chk("rst_drop_conf", WIDTH'(wr_conf), 32'h0);
    for (int r = 0; r < NREGS; r++) model[r] = '0;

    // ---------------- multi-read under random writes ----------------
    for (int cyc = 0; cyc < 40; cyc++) begin
      for (int p = 0; p < NWR; p++) begin
        r_en[p]   = ($urandom_range(0, 3) != 0);
        r_addr[p] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 7))
                                                : (($urandom_range(0, 1) != 0) ? 3'd7 : 3'd0);
        r_size[p] = 2'($urandom_range(0, 3));
        r_data[p] = $urandom;
        set_wr(p, r_en[p], r_addr[p], r_size[p], r_data[p]);
      end
      set_rd(0, (cyc % 2 == 0) ? 3'd7 : 3'd0);
      set_rd(1, (cyc % 2 == 0) ? 3'd0 : 3'd7);
      for (int r = 0; r < NREGS; r++) nxt[r] = model[r];
      for (int p = 0; p < NWR; p++) begin
        if (r_en[p]) nxt[r_addr[p]] = ref_merge(nxt[r_addr[p]], r_size[p], r_data[p]);
      end
      #1;
      for (int q = 0; q < NRD; q++) begin
        ra     = rd_addr[q*AW +: AW];
        exp_rd = model[ra];
        if (BYP && ((r_en[0] && r_addr[0] == ra) || (r_en[1] && r_addr[1] == ra)))
          exp_rd = nxt[ra];
        chk($sformatf("mr_c%0d_p%0d", cyc, q), rd(q), exp_rd);
      end
      exp_conf = r_en[0] && r_en[1] && (r_addr[0] == r_addr[1]);
      tick();
      chk($sformatf("mr_conf_c%0d", cyc), WIDTH'(wr_conf), WIDTH'(exp_conf));
      for (int r = 0; r < NREGS; r++) model[r] = nxt[r];
    end
    wr_en = '0;
    #1;
    set_rd(0, 3'd7);
    set_rd(1, 3'd0);
    #1;
    chk("mr_final_r7", rd(0), model[7]);
    chk("mr_final_r0", rd(1), model[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
